// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code output presented over a valid/ready handshake.
// Each accepted step changes exactly one gray_out bit; bin_out exposes the matching binary count.
//
// state | meaning
// IDLE  | no code pending, gray_valid=0
// HOLD  | gray_out holds a code not yet consumed, gray_valid=1
module gray_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             gray_valid,
    input  logic             gray_ready,
    output logic             wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hs_state_t;

    hs_state_t        state;
    logic             slot_free;
    logic             xfer;
    logic             at_end;
    logic [WIDTH-1:0] bin_next;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // The terminal count for the current direction is exactly the condition
    // under which the next step wraps, so one compare serves both.
    always_comb begin
        at_end    = up_dn ? (bin_out == MAX_VAL) : (bin_out == '0);
        bin_next  = up_dn ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));
        slot_free = (state == IDLE) || gray_ready;
        xfer      = (state == HOLD) && gray_ready;
    end

    assign tc = at_end;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state      <= IDLE;
            gray_valid <= 1'b0;
            bin_out    <= '0;
            gray_out   <= '0;
            wrap       <= 1'b0;
        end else if (load) begin
            state      <= HOLD;
            gray_valid <= 1'b1;
            bin_out    <= load_val;
            gray_out   <= to_gray(load_val);
            wrap       <= 1'b0;
        end else if (en && slot_free) begin
            state      <= HOLD;
            gray_valid <= 1'b1;
            bin_out    <= bin_next;
            gray_out   <= to_gray(bin_next);
            wrap       <= at_end;
        end else if (xfer) begin
            state      <= IDLE;
            gray_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a 4-bit and an 8-bit instance share stimulus and are
// checked every cycle against an arithmetic model, plus directed literal checks.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rstn, clr, load, en, up_dn, gray_ready;
    logic [7:0] load_val;

    logic [3:0] gray4, bin4;
    logic       valid4, wrap4, tc4;
    logic [7:0] gray8, bin8;
    logic       valid8, wrap8, tc8;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    int m_bin[2], m_valid[2], m_wrap[2], m_stepped[2], m_prev[2];
    int modv[2] = '{16, 256};

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .up_dn(up_dn), .gray_out(gray4), .bin_out(bin4), .gray_valid(valid4),
        .gray_ready(gray_ready), .wrap(wrap4), .tc(tc4)
    );

    gray_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .gray_out(gray8), .bin_out(bin8), .gray_valid(valid8),
        .gray_ready(gray_ready), .wrap(wrap8), .tc(tc8)
    );

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Independent Gray-to-binary converter: prefix XOR from the MSB down.
    function automatic int gray_dec(input int g, input int w);
        int b = 0;
        int acc = 0;
        for (int i = w - 1; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            b = b | (acc << i);
        end
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: applies the per-edge priority rules with plain modular arithmetic.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_stepped[k] = 0;
            if (!rstn || clr) begin
                m_bin[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
            end else if (load) begin
                m_bin[k] = int'(load_val) % modv[k]; m_valid[k] = 1; m_wrap[k] = 0;
            end else if (en && (!m_valid[k] || gray_ready)) begin
                m_prev[k] = gray_of(m_bin[k]);
                if (up_dn) begin
                    m_wrap[k] = (m_bin[k] + 1 >= modv[k]);
                    m_bin[k] = (m_bin[k] + 1) % modv[k];
                end else begin
                    m_wrap[k] = (m_bin[k] == 0);
                    m_bin[k] = (m_bin[k] + modv[k] - 1) % modv[k];
                end
                m_valid[k] = 1; m_stepped[k] = 1;
            end else begin
                if (m_valid[k] && gray_ready) m_valid[k] = 0;
                m_wrap[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bin4",   int'(bin4),   m_bin[0]);
            chk("gray4",  int'(gray4),  gray_of(m_bin[0]));
            chk("valid4", int'(valid4), m_valid[0]);
            chk("wrap4",  int'(wrap4),  m_wrap[0]);
            chk("tc4",    int'(tc4),    up_dn ? int'(m_bin[0] == 15) : int'(m_bin[0] == 0));
            chk("bin8",   int'(bin8),   m_bin[1]);
            chk("gray8",  int'(gray8),  gray_of(m_bin[1]));
            chk("valid8", int'(valid8), m_valid[1]);
            chk("wrap8",  int'(wrap8),  m_wrap[1]);
            chk("tc8",    int'(tc8),    up_dn ? int'(m_bin[1] == 255) : int'(m_bin[1] == 0));
            if (m_stepped[0]) chk("onebit4", $countones(int'(gray4) ^ m_prev[0]), 1);
            if (m_stepped[1]) chk("onebit8", $countones(int'(gray8) ^ m_prev[1]), 1);
            if (valid8 && gray_ready) chk("decode8", gray_dec(int'(gray8), 8), int'(bin8));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g4 [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

    initial begin
        rstn = 0; clr = 0; load = 0; en = 0; up_dn = 1; gray_ready = 1; load_val = '0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_gray4", int'(gray4), 0);
        chk("rst_valid4", int'(valid4), 0);
        chk("rst_wrap4", int'(wrap4), 0);
        chk("rst_tc_up", int'(tc4), 0);
        up_dn = 0; #1;
        chk("rst_tc_dn", int'(tc4), 1);
        up_dn = 1;

        // Free-run up through the 4-bit wrap.
        rstn = 1; en = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("run_gray4", int'(gray4), int'(exp_g4[i]));
            chk("run_wrap4", int'(wrap4), int'(i == 15));
            chk("run_tc4", int'(tc4), int'(i == 14));
        end
        tick();
        chk("run17_gray4", int'(gray4), 4'b0001);

        // Back to 0 via clear, then count down through the wrap.
        en = 0; clr = 1; tick(); clr = 0;
        up_dn = 0; #1;
        chk("dn_tc_at0", int'(tc4), 1);
        en = 1; tick();
        chk("dn_gray4", int'(gray4), 4'b1000);
        chk("dn_bin4", int'(bin4), 15);
        chk("dn_wrap4", int'(wrap4), 1);
        chk("dn_tc_at15", int'(tc4), 0);
        tick();
        chk("dn2_bin4", int'(bin4), 14);
        chk("dn2_wrap4", int'(wrap4), 0);
        en = 0;

        // Backpressure: stall at bin 5, then transfer and step on the same edge.
        load = 1; load_val = 8'd4; tick(); load = 0;
        up_dn = 1; en = 1; tick();
        chk("bp_gray4", int'(gray4), 4'b0111);
        gray_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_gray4", int'(gray4), 4'b0111);
            chk("bp_hold_valid4", int'(valid4), 1);
        end
        gray_ready = 1; tick();
        chk("bp_rel_gray4", int'(gray4), 4'b0101);
        chk("bp_rel_bin4", int'(bin4), 6);
        en = 0;

        // Load beats en; clr beats load.
        gray_ready = 0; load = 1; load_val = 8'h0A; en = 1; tick();
        chk("ld_bin4", int'(bin4), 4'b1010);
        chk("ld_gray4", int'(gray4), 4'b1111);
        chk("ld_valid4", int'(valid4), 1);
        clr = 1; tick();
        chk("clr_bin4", int'(bin4), 0);
        chk("clr_gray4", int'(gray4), 0);
        chk("clr_valid4", int'(valid4), 0);
        clr = 0; load = 0; en = 0;

        // Reset while holding bin 9.
        load = 1; load_val = 8'd9; tick(); load = 0;
        chk("mr_pre_bin4", int'(bin4), 9);
        rstn = 0; tick();
        chk("mr_bin4", int'(bin4), 0);
        chk("mr_valid4", int'(valid4), 0);
        chk("mr_tc4", int'(tc4), int'(!up_dn));
        rstn = 1; gray_ready = 1; en = 1; tick();
        chk("mr_resume_bin4", int'(bin4), 1);

        // Direction flips with no idle cycle.
        for (int i = 0; i < 8; i++) begin
            up_dn = (i % 3) != 0;
            tick();
        end

        // Full 8-bit run with intermittent backpressure.
        clr = 1; tick(); clr = 0; up_dn = 1;
        for (int i = 0; i < 320; i++) begin
            gray_ready = (i % 5) != 4;
            tick();
        end
        gray_ready = 1;
        for (int i = 0; i < 256; i++) tick();

        en = 0; tick(); tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
